div_scheduler: RTL and testbench
================================

# div_scheduler

Shares a single iterative `divider` (D_W-bit, Q(D_W-FRAC_W).FRAC_W signed quotient) among N_REQ requesters in the MHA datapath, e.g. per-lane softmax normalisation units. Each requester gets a valid/ready request channel with round-robin arbitration. The block drives the divider's hold-until-valid start protocol, bypasses divide-by-zero with saturation, and returns each quotient tagged with the requester ID on a valid/ready response channel.

## Interface
- N_REQ, 4: number of requesters (2..16).
- D_W, 16: operand/quotient width; matches divider D_W.
- FRAC_W, 13: fractional bits of the quotient format.
- I_CLK  in  1  clock; all logic on rising edge.
- I_RST  in  1  reset, synchronous, active-high.
- I_REQ_VLD  in  N_REQ  per-requester request valid.
- I_REQ_DIVIDEND  in  N_REQ*D_W  packed dividends, requester i at [i*D_W +: D_W].
- I_REQ_DIVISOR  in  N_REQ*D_W  packed divisors, same packing.
- O_REQ_RDY  out  N_REQ  one-hot grant; request i accepted when I_REQ_VLD[i] & O_REQ_RDY[i].
- O_DIV_START  out  1  divider start; held until I_DIV_OUT_VLD.
- O_DIV_DIVIDEND  out  D_W  registered operand, stable while O_DIV_START=1.
- O_DIV_DIVISOR  out  D_W  registered operand, stable while O_DIV_START=1.
- I_DIV_QUOTIENT  in  D_W  divider quotient.
- I_DIV_OUT_VLD  in  1  divider result valid.
- O_RSP_VLD  out  1  response valid.
- O_RSP_ID  out  $clog2(N_REQ)  requester index of response.
- O_RSP_QUOTIENT  out  D_W  quotient.
- O_RSP_DZ  out  1  divisor was zero; quotient saturated.
- I_RSP_RDY  in  1  response consumer ready.
- O_BUSY  out  1  high whenever state != IDLE or O_RSP_VLD=1.

## Operation
- Reset values: O_REQ_RDY=0, O_DIV_START=0, O_DIV_DIVIDEND=0, O_DIV_DIVISOR=0, O_RSP_VLD=0, O_RSP_ID=0, O_RSP_QUOTIENT=0, O_RSP_DZ=0, O_BUSY=0, state=IDLE, RR pointer=N_REQ-1, so requester 0 wins first.
- States: IDLE, RUN, DRAIN.
- IDLE: grant allowed when at least one I_REQ_VLD is high, O_RSP_VLD=0 or I_RSP_RDY=1, and I_DIV_OUT_VLD=0. O_REQ_RDY is combinational: one-hot on the first valid index after the RR pointer. On accept, latch operands and ID, and set the pointer to the granted index.
  - If divisor != 0: go to RUN.
  - If divisor == 0: stay in IDLE and load the response register directly. Quotient is 2^(D_W-1)-1 if dividend[D_W-1]=0, otherwise -2^(D_W-1). DZ=1. The divider is not started.
- RUN: O_DIV_START=1. When I_DIV_OUT_VLD=1, capture I_DIV_QUOTIENT into the response register with DZ=0 and go to DRAIN.
- DRAIN: O_DIV_START=0. Go to IDLE when I_DIV_OUT_VLD=0.
- Response register: O_RSP_VLD set on load and cleared on I_RSP_RDY. Fields are stable while O_RSP_VLD & !I_RSP_RDY. A load and an accept in the same cycle keep VLD=1 with the new data.
- Divider contract: O_OUT_VLD stays high while start is held, and drops after start falls. The quotient equals {q[D_W-1+FRAC_W], q[D_W-2:0]} of (dividend<<FRAC_W)/divisor (signed). This block does no arithmetic beyond zero detection and saturation.
- Reset mid-RUN or mid-DRAIN: everything returns to reset values next cycle. The in-flight result is discarded. The IDLE grant gate on I_DIV_OUT_VLD=0 blocks reissue until the divider has dropped a stale valid.

## Timing
- Accept in cycle T: O_DIV_START=1 and operands valid from T+1.
- I_DIV_OUT_VLD first high in cycle T+k: O_RSP_VLD=1 and O_DIV_START=0 from T+k+1.
- The next grant is no earlier than the cycle after I_DIV_OUT_VLD is seen low.
- Divide-by-zero: accept at T, O_RSP_VLD=1 at T+1. A new grant is possible at T+1 if I_RSP_RDY=1.
- At most one operation is in flight, plus one buffered response.
- No combinational path from I_REQ_* to O_DIV_* or O_RSP_*. O_REQ_RDY depends combinationally on I_REQ_VLD, I_RSP_RDY and I_DIV_OUT_VLD only.

## Structure
- Package mha_div_pkg holds:
  - D_W and FRAC_W defaults;
  - the state enum (IDLE/RUN/DRAIN);
  - the saturation constants Q_MAX/Q_MIN as functions of D_W.
- Sub-module rr_arbiter (N parameter) takes request vector, pointer and enable, and returns a one-hot grant and an encoded index.
- The FSM and response register stay in div_scheduler.

## Test plan
- Single request: requester 2, dividend 16'h2000, divisor 16'h4000. Expect O_RSP_QUOTIENT=16'h1000, ID=2, DZ=0. O_DIV_START falls the cycle after I_DIV_OUT_VLD.
- Divide-by-zero:
  - requester 1, 16'h1234/0: expect 16'h7FFF, DZ=1 one cycle after accept, O_DIV_START never asserted;
  - 16'hE000/0: expect 16'h8000.
- Round-robin: all 4 requesters hold valid with random non-zero operands. Grant order 0,1,2,3,0,1. Each quotient matches the signed reference model.
- Backpressure: hold I_RSP_RDY=0 for 20 cycles after a response. O_RSP_* must stay stable, O_REQ_RDY must stay 0, and no second O_DIV_START may be issued.
- Reset mid-RUN: assert I_RST for 1 cycle while O_DIV_START=1. Next cycle all outputs are at reset values. The next request completes correctly with requester 0 granted first.
- Random soak: 1000 random requests across all requesters with random I_RSP_RDY. Every accepted request yields exactly one response with the correct ID and quotient, in accept order.

Source files
------------

// File: rtl/mha_div_pkg.sv
// rtl/mha_div_pkg.sv - shared types and constants for the divider scheduler
package mha_div_pkg;

  localparam int D_W_DEF    = 16;
  localparam int FRAC_W_DEF = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Largest positive two's-complement value of a w-bit word
  function automatic logic [63:0] q_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of a w-bit word (as a bit pattern)
  function automatic logic [63:0] q_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, first request after the pointer wins
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW:0]  sh;
  logic [N-1:0] rot;
  logic [N-1:0] first;

  // Rotate so index ptr+1 sits at bit 0, isolate the lowest request, rotate back
  always_comb begin
    sh    = {1'b0, ptr} + (IW + 1)'(1);
    rot   = N'({req, req} >> sh);
    first = rot & (~rot + N'(1));
    grant = en ? N'(({first, first} << sh) >> N) : '0;
  end

  // One-hot to binary index of the granted requester
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/div_scheduler.sv
// rtl/div_scheduler.sv - shares one iterative divider among N_REQ requesters
module div_scheduler
  import mha_div_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int D_W    = D_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                       I_CLK,
  input  logic                       I_RST,
  input  logic [N_REQ-1:0]           I_REQ_VLD,
  input  logic [N_REQ*D_W-1:0]       I_REQ_DIVIDEND,
  input  logic [N_REQ*D_W-1:0]       I_REQ_DIVISOR,
  output logic [N_REQ-1:0]           O_REQ_RDY,
  output logic                       O_DIV_START,
  output logic [D_W-1:0]             O_DIV_DIVIDEND,
  output logic [D_W-1:0]             O_DIV_DIVISOR,
  input  logic [D_W-1:0]             I_DIV_QUOTIENT,
  input  logic                       I_DIV_OUT_VLD,
  output logic                       O_RSP_VLD,
  output logic [$clog2(N_REQ)-1:0]   O_RSP_ID,
  output logic [D_W-1:0]             O_RSP_QUOTIENT,
  output logic                       O_RSP_DZ,
  input  logic                       I_RSP_RDY,
  output logic                       O_BUSY
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [D_W-1:0] Q_MAX = D_W'(q_max(D_W));
  localparam logic [D_W-1:0] Q_MIN = D_W'(q_min(D_W));

  // The quotient format only makes sense with fewer fraction bits than the word
  if (FRAC_W < 0 || FRAC_W >= D_W) begin : g_bad_frac_w
    $error("FRAC_W must lie in [0, D_W)");
  end

  state_t            state;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     cur_id;
  logic [IW-1:0]     arb_idx;
  logic [N_REQ-1:0]  arb_grant;
  logic              arb_en;
  logic              accept;
  logic [D_W-1:0]    sel_dd;
  logic [D_W-1:0]    sel_ds;

  // Grant only when idle, the response slot frees this cycle, and no stale divider valid remains
  assign arb_en    = (state == IDLE) && (!O_RSP_VLD || I_RSP_RDY) && !I_DIV_OUT_VLD;
  assign O_REQ_RDY = arb_grant;
  assign accept    = |arb_grant;
  assign O_BUSY    = (state != IDLE) || O_RSP_VLD;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .req   (I_REQ_VLD),
    .ptr   (ptr),
    .en    (arb_en),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  // Select the operands of the granted requester
  always_comb begin
    sel_dd = '0;
    sel_ds = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_dd = I_REQ_DIVIDEND[i*D_W +: D_W];
        sel_ds = I_REQ_DIVISOR[i*D_W +: D_W];
      end
    end
  end

  // Scheduler FSM, divider handshake and one-entry response register
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state          <= IDLE;
      ptr            <= IW'(N_REQ - 1);
      cur_id         <= '0;
      O_DIV_START    <= 1'b0;
      O_DIV_DIVIDEND <= '0;
      O_DIV_DIVISOR  <= '0;
      O_RSP_VLD      <= 1'b0;
      O_RSP_ID       <= '0;
      O_RSP_QUOTIENT <= '0;
      O_RSP_DZ       <= 1'b0;
    end else begin
      if (O_RSP_VLD && I_RSP_RDY) O_RSP_VLD <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            ptr            <= arb_idx;
            cur_id         <= arb_idx;
            O_DIV_DIVIDEND <= sel_dd;
            O_DIV_DIVISOR  <= sel_ds;
            if (sel_ds != '0) begin
              state       <= RUN;
              O_DIV_START <= 1'b1;
            end else begin
              // Divide-by-zero never reaches the divider; answer saturated right away
              O_RSP_VLD      <= 1'b1;
              O_RSP_ID       <= arb_idx;
              O_RSP_QUOTIENT <= sel_dd[D_W-1] ? Q_MIN : Q_MAX;
              O_RSP_DZ       <= 1'b1;
            end
          end
        end
        RUN: begin
          if (I_DIV_OUT_VLD) begin
            O_DIV_START    <= 1'b0;
            O_RSP_VLD      <= 1'b1;
            O_RSP_ID       <= cur_id;
            O_RSP_QUOTIENT <= I_DIV_QUOTIENT;
            O_RSP_DZ       <= 1'b0;
            state          <= DRAIN;
          end
        end
        DRAIN: begin
          if (!I_DIV_OUT_VLD) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_scheduler.sv
// tb/tb_div_scheduler.sv - directed and soak bench for div_scheduler
module tb_div_scheduler;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int LAT = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_vld;
  logic [N*DW-1:0] req_dd;
  logic [N*DW-1:0] req_ds;
  logic [N-1:0]    req_rdy;
  logic            div_start;
  logic [DW-1:0]   div_dd;
  logic [DW-1:0]   div_ds;
  logic [DW-1:0]   div_q = '0;
  logic            div_ov = 1'b0;
  logic            rsp_vld;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_q;
  logic            rsp_dz;
  logic            rsp_rdy;
  logic            busy;

  int errors = 0;
  int checks = 0;
  int start_count = 0;
  logic start_prev = 1'b0;
  int div_cnt = 0;

  always #5 clk = ~clk;

  div_scheduler #(.N_REQ(N), .D_W(DW), .FRAC_W(13)) dut (
    .I_CLK(clk), .I_RST(rst),
    .I_REQ_VLD(req_vld), .I_REQ_DIVIDEND(req_dd), .I_REQ_DIVISOR(req_ds),
    .O_REQ_RDY(req_rdy),
    .O_DIV_START(div_start), .O_DIV_DIVIDEND(div_dd), .O_DIV_DIVISOR(div_ds),
    .I_DIV_QUOTIENT(div_q), .I_DIV_OUT_VLD(div_ov),
    .O_RSP_VLD(rsp_vld), .O_RSP_ID(rsp_id), .O_RSP_QUOTIENT(rsp_q), .O_RSP_DZ(rsp_dz),
    .I_RSP_RDY(rsp_rdy), .O_BUSY(busy)
  );

  // Signed Q2.13 reference: {dz, quotient}
  function automatic logic [16:0] ref_div(input logic [15:0] dd, input logic [15:0] ds);
    longint n, d, q;
    if (ds == 16'd0) return {1'b1, (dd[15] ? 16'h8000 : 16'h7FFF)};
    n = longint'($signed(dd)) * 64'sd8192;
    d = longint'($signed(ds));
    q = n / d;
    return {1'b0, q[28], q[14:0]};
  endfunction

  // Divider model: valid after LAT cycles of held start, drops after start falls
  always @(posedge clk) begin
    if (div_start !== 1'b1) begin
      div_cnt <= 0;
      div_ov  <= 1'b0;
    end else if (div_cnt == LAT) begin
      div_ov <= 1'b1;
      div_q  <= 16'(ref_div(div_dd, div_ds));
    end else begin
      div_cnt <= div_cnt + 1;
    end
  end

  // Count divider start rising edges
  always @(posedge clk) begin
    if (div_start === 1'b1 && start_prev !== 1'b1) start_count++;
    start_prev = div_start;
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (rsp_vld === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy === 1'b0 && div_ov === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic set_req(input int i, input logic [15:0] dd, input logic [15:0] ds);
    req_dd[i*DW +: DW] = dd;
    req_ds[i*DW +: DW] = ds;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_vld = '0; req_dd = '0; req_ds = '0; rsp_rdy = 1'b0;
    repeat (3) tick();
    checks++; if (req_rdy !== 4'b0000) begin errors++; $display("FAIL reset_rdy got %b want 0000", req_rdy); end
    checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", div_start); end
    checks++; if (div_dd !== 16'h0 || div_ds !== 16'h0) begin errors++; $display("FAIL reset_operands got %h/%h want 0/0", div_dd, div_ds); end
    checks++; if (rsp_vld !== 1'b0 || rsp_dz !== 1'b0) begin errors++; $display("FAIL reset_rsp_flags got vld=%b dz=%b want 0 0", rsp_vld, rsp_dz); end
    checks++; if (rsp_id !== 2'd0 || rsp_q !== 16'h0) begin errors++; $display("FAIL reset_rsp_data got id=%0d q=%h want 0 0000", rsp_id, rsp_q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    bit ok;
    tick();
    set_req(2, 16'h2000, 16'h4000); req_vld = 4'b0100; rsp_rdy = 1'b0;
    #1;
    checks++; if (req_rdy !== 4'b0100) begin errors++; $display("FAIL single_grant got %b want 0100", req_rdy); end
    tick();
    req_vld = '0;
    checks++; if (div_start !== 1'b1) begin errors++; $display("FAIL single_start got %b want 1", div_start); end
    checks++; if (div_dd !== 16'h2000 || div_ds !== 16'h4000) begin errors++; $display("FAIL single_operands got %h/%h want 2000/4000", div_dd, div_ds); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (div_ov === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_div_timeout got %b want 1", ok); end
    tick();
    checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL single_start_fall got %b want 0", div_start); end
    checks++; if (rsp_vld !== 1'b1) begin errors++; $display("FAIL single_rsp_vld got %b want 1", rsp_vld); end
    checks++; if (rsp_id !== 2'd2 || rsp_q !== 16'h1000 || rsp_dz !== 1'b0) begin errors++; $display("FAIL single_rsp got id=%0d q=%h dz=%b want 2 1000 0", rsp_id, rsp_q, rsp_dz); end
    rsp_rdy = 1'b1;
    tick();
    checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL single_rsp_pop got %b want 0", rsp_vld); end
    wait_idle(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_idle_timeout got %b want 1", ok); end
  endtask

  task automatic test_div_zero;
    int sc;
    sc = start_count;
    rsp_rdy = 1'b0;
    set_req(1, 16'h1234, 16'h0000); req_vld = 4'b0010;
    #1;
    checks++; if (req_rdy !== 4'b0010) begin errors++; $display("FAIL dz_grant got %b want 0010", req_rdy); end
    tick();
    req_vld = '0;
    checks++; if (rsp_vld !== 1'b1 || rsp_dz !== 1'b1) begin errors++; $display("FAIL dz_pos_flags got vld=%b dz=%b want 1 1", rsp_vld, rsp_dz); end
    checks++; if (rsp_id !== 2'd1 || rsp_q !== 16'h7FFF) begin errors++; $display("FAIL dz_pos_data got id=%0d q=%h want 1 7fff", rsp_id, rsp_q); end
    checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL dz_no_start got %b want 0", div_start); end
    set_req(3, 16'hE000, 16'h0000); req_vld = 4'b1000; rsp_rdy = 1'b1;
    #1;
    checks++; if (req_rdy !== 4'b1000) begin errors++; $display("FAIL dz_grant_while_pop got %b want 1000", req_rdy); end
    tick();
    req_vld = '0;
    checks++; if (rsp_vld !== 1'b1 || rsp_dz !== 1'b1) begin errors++; $display("FAIL dz_neg_flags got vld=%b dz=%b want 1 1", rsp_vld, rsp_dz); end
    checks++; if (rsp_id !== 2'd3 || rsp_q !== 16'h8000) begin errors++; $display("FAIL dz_neg_data got id=%0d q=%h want 3 8000", rsp_id, rsp_q); end
    tick();
    checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL dz_pop got %b want 0", rsp_vld); end
    checks++; if (start_count !== sc) begin errors++; $display("FAIL dz_start_count got %0d want %0d", start_count, sc); end
  endtask

  task automatic test_round_robin;
    int order [6] = '{0, 1, 2, 3, 0, 1};
    logic [15:0] q_exp [4] = '{16'h1000, 16'h4000, 16'hC000, 16'hF000};
    int n_acc, n_rsp, gi;
    n_acc = 0; n_rsp = 0;
    set_req(0, 16'h1000, 16'h2000);
    set_req(1, 16'h4000, 16'h2000);
    set_req(2, 16'hE000, 16'h1000);
    set_req(3, 16'h2000, 16'hC000);
    req_vld = 4'b1111; rsp_rdy = 1'b1;
    for (int c = 0; c < 400 && n_rsp < 6; c++) begin
      if (n_acc == 6) req_vld = '0;
      #1;
      if (|(req_vld & req_rdy)) begin
        checks++; if (req_rdy !== 4'(1 << order[n_acc])) begin errors++; $display("FAIL rr_grant%0d got %b want index %0d", n_acc, req_rdy, order[n_acc]); end
        n_acc++;
      end
      if (rsp_vld === 1'b1 && rsp_rdy) begin
        gi = order[n_rsp];
        checks++; if (rsp_id !== 2'(gi) || rsp_q !== q_exp[gi] || rsp_dz !== 1'b0) begin errors++; $display("FAIL rr_rsp%0d got id=%0d q=%h dz=%b want %0d %h 0", n_rsp, rsp_id, rsp_q, rsp_dz, gi, q_exp[gi]); end
        n_rsp++;
      end
      @(negedge clk);
    end
    req_vld = '0;
    checks++; if (n_rsp !== 6) begin errors++; $display("FAIL rr_count got %0d want 6", n_rsp); end
  endtask

  task automatic test_backpressure;
    bit ok;
    int sc;
    wait_idle(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_idle_timeout got %b want 1", ok); end
    set_req(0, 16'h4000, 16'h2000);
    set_req(2, 16'h2000, 16'h4000);
    req_vld = 4'b0101; rsp_rdy = 1'b0;
    #1;
    checks++; if (req_rdy !== 4'b0100) begin errors++; $display("FAIL bp_grant got %b want 0100", req_rdy); end
    tick();
    req_vld = 4'b0001;
    wait_rsp(50, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_rsp_timeout got %b want 1", ok); end
    sc = start_count;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++; if (rsp_vld !== 1'b1 || rsp_id !== 2'd2 || rsp_q !== 16'h1000) begin errors++; $display("FAIL bp_hold%0d got vld=%b id=%0d q=%h want 1 2 1000", c, rsp_vld, rsp_id, rsp_q); end
      checks++; if (req_rdy !== 4'b0000) begin errors++; $display("FAIL bp_rdy%0d got %b want 0000", c, req_rdy); end
    end
    checks++; if (start_count !== sc) begin errors++; $display("FAIL bp_start_count got %0d want %0d", start_count, sc); end
    rsp_rdy = 1'b1;
    #1;
    checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL bp_release_grant got %b want 0001", req_rdy); end
    tick();
    req_vld = '0;
    checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL bp_release_pop got %b want 0", rsp_vld); end
    wait_rsp(50, ok);
    checks++; if (ok !== 1'b1 || rsp_id !== 2'd0 || rsp_q !== 16'h4000) begin errors++; $display("FAIL bp_second got ok=%b id=%0d q=%h want 1 0 4000", ok, rsp_id, rsp_q); end
  endtask

  task automatic test_reset_mid_run;
    bit ok;
    wait_idle(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mr_idle_timeout got %b want 1", ok); end
    set_req(2, 16'h2000, 16'h4000); req_vld = 4'b0100; rsp_rdy = 1'b1;
    tick();
    req_vld = '0;
    checks++; if (div_start !== 1'b1) begin errors++; $display("FAIL mr_start got %b want 1", div_start); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (div_start !== 1'b0 || div_dd !== 16'h0 || div_ds !== 16'h0) begin errors++; $display("FAIL mr_div_outputs got start=%b %h/%h want 0 0/0", div_start, div_dd, div_ds); end
    checks++; if (rsp_vld !== 1'b0 || rsp_id !== 2'd0 || rsp_q !== 16'h0 || rsp_dz !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mr_rsp_outputs got vld=%b id=%0d q=%h dz=%b busy=%b want all 0", rsp_vld, rsp_id, rsp_q, rsp_dz, busy); end
    set_req(0, 16'h1000, 16'h2000);
    set_req(3, 16'h2000, 16'h4000);
    req_vld = 4'b1001;
    #1;
    checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL mr_first_grant got %b want 0001", req_rdy); end
    tick();
    req_vld = '0;
    wait_rsp(50, ok);
    checks++; if (ok !== 1'b1 || rsp_id !== 2'd0 || rsp_q !== 16'h1000 || rsp_dz !== 1'b0) begin errors++; $display("FAIL mr_after got ok=%b id=%0d q=%h dz=%b want 1 0 1000 0", ok, rsp_id, rsp_q, rsp_dz); end
  endtask

  task automatic test_soak;
    logic [16:0] exp_q [$];
    logic [1:0]  exp_id [$];
    logic [16:0] eq;
    logic [1:0]  ei;
    bit took [N];
    int issued, got, gi;
    bit ok;
    wait_idle(ok);
    issued = 0; got = 0;
    for (int i = 0; i < N; i++) took[i] = 1'b0;
    req_vld = '0;
    for (int c = 0; c < 40000 && got < 1000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if ((!req_vld[i] || took[i]) && issued < 1000) begin
          set_req(i, 16'($urandom), ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(1, 65535)));
          req_vld[i] = 1'b1;
          issued++;
        end else if (took[i]) begin
          req_vld[i] = 1'b0;
        end
        took[i] = 1'b0;
      end
      rsp_rdy = ($urandom_range(0, 3) != 0);
      #1;
      if (|(req_vld & req_rdy)) begin
        gi = 0;
        for (int i = 0; i < N; i++) if (req_rdy[i]) gi = i;
        took[gi] = 1'b1;
        exp_q.push_back(ref_div(req_dd[gi*DW +: DW], req_ds[gi*DW +: DW]));
        exp_id.push_back(2'(gi));
      end
      if (rsp_vld === 1'b1 && rsp_rdy) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL soak_unexpected_rsp got id=%0d want no response", rsp_id);
        end else begin
          eq = exp_q.pop_front();
          ei = exp_id.pop_front();
          checks++; if ({rsp_dz, rsp_q} !== eq || rsp_id !== ei) begin errors++; $display("FAIL soak_rsp%0d got id=%0d dz=%b q=%h want %0d %b %h", got, rsp_id, rsp_dz, rsp_q, ei, eq[16], eq[15:0]); end
        end
        got++;
      end
    end
    req_vld = '0;
    checks++; if (got !== 1000 || exp_q.size() !== 0) begin errors++; $display("FAIL soak_count got %0d responses %0d pending want 1000 0", got, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_div_zero();
    test_round_robin();
    test_backpressure();
    test_reset_mid_run();
    test_soak();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
